// File: rtl/cursor_plot_ctrl.sv
// Board cursor and plot-request sequencer: edge-detected move/place/turn inputs
// drive a cursor plus erase/box/disk cell-draw requests over a valid/ready handshake.
module cursor_plot_ctrl #(
    parameter int BOARD_N    = 8,
    parameter int CELL_PITCH = 13,
    parameter int ORIGIN_X   = 9,
    parameter int ORIGIN_Y   = 9,
    parameter int WRAP       = 0,
    parameter int XW         = 8,
    parameter int YW         = 7
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       move_up,
    input  logic                       move_down,
    input  logic                       move_left,
    input  logic                       move_right,
    input  logic                       place_disk,
    input  logic                       turn_side,
    input  logic                       draw_ready,
    output logic                       draw_req,
    output logic [XW-1:0]              x_plot,
    output logic [YW-1:0]              y_plot,
    output logic [1:0]                 select,
    output logic [$clog2(BOARD_N)-1:0] x,
    output logic [$clog2(BOARD_N)-1:0] y,
    output logic                       side,
    output logic                       busy
);
    localparam int IW = $clog2(BOARD_N);
    localparam logic [IW-1:0] MAX_I  = IW'(BOARD_N - 1);
    localparam logic [IW-1:0] ONE_I  = IW'(1);
    localparam logic [XW-1:0] X_ORG  = XW'(ORIGIN_X);
    localparam logic [YW-1:0] Y_ORG  = YW'(ORIGIN_Y);
    localparam logic [XW-1:0] X_STEP = XW'(CELL_PITCH);
    localparam logic [YW-1:0] Y_STEP = YW'(CELL_PITCH);
    localparam logic [XW-1:0] X_JUMP = XW'((BOARD_N - 1) * CELL_PITCH);
    localparam logic [YW-1:0] Y_JUMP = YW'((BOARD_N - 1) * CELL_PITCH);

    typedef enum logic [2:0] {ST_START, ST_IDLE, ST_ERASE, ST_BOX, ST_DISK} state_t;

    state_t          state_q, state_d;
    logic [5:0]      in_now, prev_q, prev_d, ev;
    logic [IW-1:0]   x_q, x_d, y_q, y_d;
    logic [XW-1:0]   cur_px_q, cur_px_d, old_px_q, old_px_d, x_plot_q, x_plot_d;
    logic [YW-1:0]   cur_py_q, cur_py_d, old_py_q, old_py_d, y_plot_q, y_plot_d;
    logic            side_q, side_d;
    logic [1:0]      select_q, select_d;

    logic            mv;
    logic [IW-1:0]   tx, ty;
    logic [XW-1:0]   tpx;
    logic [YW-1:0]   tpy;

    // bit order: turn, place, up, down, left, right
    assign in_now = {turn_side, place_disk, move_up, move_down, move_left, move_right};
    assign ev     = in_now & ~prev_q;

    // Target cell for the highest-priority move edge; mv=0 means a clamped no-op.
    always_comb begin
        mv  = 1'b0;
        tx  = x_q;
        ty  = y_q;
        tpx = cur_px_q;
        tpy = cur_py_q;
        if (ev[3]) begin
            if (y_q != '0)          begin ty = y_q - ONE_I; tpy = cur_py_q - Y_STEP; mv = 1'b1; end
            else if (WRAP != 0)     begin ty = MAX_I;       tpy = cur_py_q + Y_JUMP; mv = 1'b1; end
        end else if (ev[2]) begin
            if (y_q != MAX_I)       begin ty = y_q + ONE_I; tpy = cur_py_q + Y_STEP; mv = 1'b1; end
            else if (WRAP != 0)     begin ty = '0;          tpy = cur_py_q - Y_JUMP; mv = 1'b1; end
        end else if (ev[1]) begin
            if (x_q != '0)          begin tx = x_q - ONE_I; tpx = cur_px_q - X_STEP; mv = 1'b1; end
            else if (WRAP != 0)     begin tx = MAX_I;       tpx = cur_px_q + X_JUMP; mv = 1'b1; end
        end else if (ev[0]) begin
            if (x_q != MAX_I)       begin tx = x_q + ONE_I; tpx = cur_px_q + X_STEP; mv = 1'b1; end
            else if (WRAP != 0)     begin tx = '0;          tpx = cur_px_q - X_JUMP; mv = 1'b1; end
        end
    end

    always_comb begin
        state_d  = state_q;
        prev_d   = in_now;
        x_d      = x_q;
        y_d      = y_q;
        cur_px_d = cur_px_q;
        cur_py_d = cur_py_q;
        old_px_d = old_px_q;
        old_py_d = old_py_q;
        x_plot_d = x_plot_q;
        y_plot_d = y_plot_q;
        select_d = select_q;
        side_d   = ev[5] ? ~side_q : side_q;
        case (state_q)
            ST_START: begin
                state_d  = ST_BOX;
                x_plot_d = cur_px_q;
                y_plot_d = cur_py_q;
                select_d = 2'd1;
            end
            ST_IDLE: begin
                if (ev[4]) begin
                    state_d  = ST_DISK;
                    x_plot_d = cur_px_q;
                    y_plot_d = cur_py_q;
                    select_d = {1'b1, side_q};
                end else if (mv) begin
                    state_d  = ST_ERASE;
                    old_px_d = cur_px_q;
                    old_py_d = cur_py_q;
                    x_d      = tx;
                    y_d      = ty;
                    cur_px_d = tpx;
                    cur_py_d = tpy;
                    x_plot_d = cur_px_q;
                    y_plot_d = cur_py_q;
                    select_d = 2'd0;
                end
            end
            ST_ERASE: begin
                if (draw_ready) begin
                    state_d  = ST_BOX;
                    x_plot_d = cur_px_q;
                    y_plot_d = cur_py_q;
                    select_d = 2'd1;
                end
            end
            ST_BOX, ST_DISK: begin
                if (draw_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_START;
        endcase
    end

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            state_q  <= ST_START;
            prev_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            cur_px_q <= X_ORG;
            cur_py_q <= Y_ORG;
            old_px_q <= X_ORG;
            old_py_q <= Y_ORG;
            x_plot_q <= X_ORG;
            y_plot_q <= Y_ORG;
            select_q <= 2'd0;
            side_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            x_q      <= x_d;
            y_q      <= y_d;
            cur_px_q <= cur_px_d;
            cur_py_q <= cur_py_d;
            old_px_q <= old_px_d;
            old_py_q <= old_py_d;
            x_plot_q <= x_plot_d;
            y_plot_q <= y_plot_d;
            select_q <= select_d;
            side_q   <= side_d;
        end
    end

    // The erase payload is taken from cur_p*_q on ERASE entry, so old_p*_q only
    // records the vacated cell for observability.
    assign draw_req = (state_q == ST_ERASE) || (state_q == ST_BOX) || (state_q == ST_DISK);
    assign busy     = (state_q != ST_IDLE);
    assign x_plot   = x_plot_q;
    assign y_plot   = y_plot_q;
    assign select   = select_q;
    assign x        = x_q;
    assign y        = y_q;
    assign side     = side_q;
endmodule

// File: tb/tb_cursor_plot_ctrl.sv
// Scoreboard bench: a clamp-mode and a wrap-mode instance share stimulus; each
// accepted draw request is popped from that instance's expected queue and compared.
module tb_cursor_plot_ctrl;
    typedef struct {int x; int y; int s;} exp_t;

    logic             clock = 1'b0;
    logic             resetn = 1'b1;
    logic [5:0]       btn = '0;   // 0 right,1 left,2 down,3 up,4 place,5 turn
    logic             draw_ready = 1'b1;
    logic [1:0]       dreq, side, busy;
    logic [1:0][7:0]  xp;
    logic [1:0][6:0]  yp;
    logic [1:0][1:0]  sel;
    logic [1:0][2:0]  cx, cy;

    int checks = 0;
    int fails  = 0;
    exp_t q0[$];
    exp_t q1[$];

    localparam logic [5:0] RIGHT = 6'b000001, LEFT = 6'b000010, DOWN = 6'b000100;
    localparam logic [5:0] UP = 6'b001000, PLACE = 6'b010000, TURN = 6'b100000;

    always #5 clock = ~clock;

    cursor_plot_ctrl #(.WRAP(0)) u_clamp (
        .clock(clock), .resetn(resetn),
        .move_up(btn[3]), .move_down(btn[2]), .move_left(btn[1]), .move_right(btn[0]),
        .place_disk(btn[4]), .turn_side(btn[5]), .draw_ready(draw_ready),
        .draw_req(dreq[0]), .x_plot(xp[0]), .y_plot(yp[0]), .select(sel[0]),
        .x(cx[0]), .y(cy[0]), .side(side[0]), .busy(busy[0]));

    cursor_plot_ctrl #(.WRAP(1)) u_wrap (
        .clock(clock), .resetn(resetn),
        .move_up(btn[3]), .move_down(btn[2]), .move_left(btn[1]), .move_right(btn[0]),
        .place_disk(btn[4]), .turn_side(btn[5]), .draw_ready(draw_ready),
        .draw_req(dreq[1]), .x_plot(xp[1]), .y_plot(yp[1]), .select(sel[1]),
        .x(cx[1]), .y(cy[1]), .side(side[1]), .busy(busy[1]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input int id, input int px, input int py, input int s);
        exp_t e;
        e.x = px; e.y = py; e.s = s;
        if (id == 0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    task automatic push2(input int px, input int py0, input int py1, input int s);
        push(0, px, py0, s);
        push(1, px, py1, s);
    endtask

    task automatic pulse(input logic [5:0] m);
        @(posedge clock); #1 btn = m;
        @(posedge clock); #1 btn = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy != 2'b00) && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        chk("idle_within_budget", 32'(n < 50), 1);
    endtask

    // Monitor: handshakes and payload stability while stalled.
    initial begin
        logic [1:0]      hold_vld;
        logic [1:0][7:0] hx;
        logic [1:0][6:0] hy;
        logic [1:0][1:0] hs;
        exp_t e;
        bit   got;
        hold_vld = '0;
        forever begin
            @(negedge clock);
            if (resetn) begin
                hold_vld = '0;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (hold_vld[i]) begin
                        chk($sformatf("stall_req_held_%0d", i), 32'(dreq[i]), 1);
                        chk($sformatf("stall_payload_%0d", i),
                            {14'd0, xp[i], yp[i], sel[i]}, {14'd0, hx[i], hy[i], hs[i]});
                    end
                    if (dreq[i] && draw_ready) begin
                        got = 0;
                        if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1; end
                        if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1; end
                        if (!got) begin
                            checks++;
                            fails++;
                            $display("FAIL unexpected_req_%0d: got (%0d,%0d,sel%0d) expected none",
                                     i, xp[i], yp[i], sel[i]);
                        end else begin
                            chk($sformatf("req_x_%0d", i), 32'(xp[i]), e.x);
                            chk($sformatf("req_y_%0d", i), 32'(yp[i]), e.y);
                            chk($sformatf("req_sel_%0d", i), 32'(sel[i]), e.s);
                        end
                    end
                    hold_vld[i] = dreq[i] && !draw_ready;
                    hx[i] = xp[i]; hy[i] = yp[i]; hs[i] = sel[i];
                end
            end
        end
    end

    initial begin
        // reset state
        #12;
        chk("rst_draw_req", 32'(dreq), 0);
        chk("rst_busy", 32'(busy), 2'b11);
        chk("rst_x_plot", 32'(xp[0]), 9);
        chk("rst_y_plot", 32'(yp[1]), 9);
        chk("rst_select", 32'(sel), 0);
        chk("rst_xy", {26'd0, cx[0], cy[1]}, 0);
        chk("rst_side", 32'(side), 0);

        // post-reset cursor draw
        push2(9, 9, 9, 1);
        @(posedge clock); #1 resetn = 1'b0;
        wait_idle();
        chk("start_xy", {20'd0, cx, cy}, 0);

        // move_right with latency checks
        push2(9, 9, 9, 0);
        push2(22, 9, 9, 1);
        @(posedge clock); #1 btn = RIGHT;
        @(posedge clock); #1;
        chk("req_after_accept", 32'(dreq), 2'b11);
        btn = '0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("busy_low_t3", 32'(busy), 0);
        chk("right_x", {26'd0, cx}, {26'd0, 3'd1, 3'd1});
        chk("right_y", {26'd0, cy}, 0);

        // back to (0,0)
        push2(22, 9, 9, 0);
        push2(9, 9, 9, 1);
        pulse(LEFT);
        wait_idle();
        chk("left_x", {26'd0, cx}, 0);

        // up at top edge: clamp no-op, wrap jumps to row 7
        push(1, 9, 9, 0);
        push(1, 9, 100, 1);
        pulse(UP);
        repeat (3) begin @(posedge clock); #1; end
        chk("clamp_up_y", 32'(cy[0]), 0);
        chk("clamp_up_idle", 32'(busy[0]), 0);
        wait_idle();
        chk("wrap_up_y", 32'(cy[1]), 7);

        // stalled erase, move_down edge during stall must be dropped
        push2(9, 9, 100, 0);
        push2(22, 9, 100, 1);
        draw_ready = 1'b0;
        pulse(RIGHT);
        pulse(DOWN);
        repeat (3) begin @(posedge clock); #1; end
        chk("stall_req", 32'(dreq), 2'b11);
        draw_ready = 1'b1;
        wait_idle();
        chk("stall_x", {26'd0, cx}, {26'd0, 3'd1, 3'd1});
        chk("stall_y", {26'd0, cy}, {26'd0, 3'd7, 3'd0});

        // turn, then place with a turn edge inside the stalled disk phase
        pulse(TURN);
        @(posedge clock); #1;
        chk("turn_side", 32'(side), 2'b11);
        chk("turn_no_busy", 32'(busy), 0);
        push2(22, 9, 100, 3);
        draw_ready = 1'b0;
        pulse(PLACE);
        pulse(TURN);
        repeat (2) begin @(posedge clock); #1; end
        chk("disk_sel_stalled", 32'(sel[0]), 3);
        draw_ready = 1'b1;
        wait_idle();
        chk("side_after_disk", 32'(side), 0);

        // place beats move_left
        push2(22, 9, 100, 2);
        pulse(PLACE | LEFT);
        wait_idle();
        chk("prio_x", {26'd0, cx}, {26'd0, 3'd1, 3'd1});

        // async reset in the middle of an erase
        draw_ready = 1'b0;
        pulse(LEFT);
        @(negedge clock); #1 resetn = 1'b1;
        #1;
        chk("midreset_req", 32'(dreq), 0);
        chk("midreset_busy", 32'(busy), 2'b11);
        push2(9, 9, 9, 1);
        @(posedge clock); #1 draw_ready = 1'b1;
        @(posedge clock); #1 resetn = 1'b0;
        wait_idle();
        chk("midreset_xy", {20'd0, cx, cy}, 0);

        repeat (3) @(posedge clock);
        #1;
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
